// File: rtl/reg_move_sequencer_if.sv
// Request and strobe bundle shared by the move sequencer and whoever feeds it.
// The requester side owns the request fields; the sequencer owns the ready
// flag, the register strobes and the status outputs.
interface reg_move_sequencer_if #(
    parameter int NUM_REGS  = 8,
    parameter int IDX_WIDTH = 3
);
    logic                 req_valid;
    logic [IDX_WIDTH-1:0] req_src;
    logic [IDX_WIDTH-1:0] req_dst;
    logic                 req_ready;
    logic [NUM_REGS-1:0]  OE;
    logic [NUM_REGS-1:0]  notLoad;
    logic                 move_done;
    logic                 busy;

    modport master (
        output req_valid, req_src, req_dst,
        input  req_ready, OE, notLoad, move_done, busy
    );

    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ready, OE, notLoad, move_done, busy
    );
endinterface

// File: rtl/reg_move_sequencer.sv
// Register-to-register move sequencer. Queued {src,dst} requests are replayed
// onto a shared bus as a one-cycle DRIVE (source output enable plus
// destination load strobe) followed by a one-cycle bus-idle SETTLE. This
// guarantees that no two sources ever drive the bus in the same cycle.
module reg_move_sequencer #(
    parameter int NUM_REGS   = 8,
    parameter int IDX_WIDTH  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clock,
    input logic            reset,
    reg_move_sequencer_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                   state;
    logic [2*IDX_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;

    logic                     push;
    logic                     pop;
    logic [2*IDX_WIDTH-1:0]   head_entry;
    logic [IDX_WIDTH-1:0]     head_src;
    logic [IDX_WIDTH-1:0]     head_dst;
    logic [NUM_REGS-1:0]      head_oe;
    logic [NUM_REGS-1:0]      head_load;
    logic                     head_valid;

    // One-hot decode restricted to existing registers; an index beyond the
    // last register decodes to all zeros.
    function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (idx == IDX_WIDTH'(i));
        end
        return onehot;
    endfunction

    // Pointer advance with explicit wrap so any depth keeps pointers in range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign bus.req_ready = (count < CNT_W'(FIFO_DEPTH));
    assign bus.busy      = (state != IDLE) || (count != '0);

    assign push       = bus.req_valid && bus.req_ready;
    assign pop        = (state != DRIVE) && (count != '0);
    assign head_entry = fifo_mem[rd_ptr];
    assign head_src   = head_entry[2*IDX_WIDTH-1:IDX_WIDTH];
    assign head_dst   = head_entry[IDX_WIDTH-1:0];
    assign head_oe    = decode(head_src);
    assign head_load  = decode(head_dst);
    // A move touching a non-existent register becomes a timing-only no-op.
    assign head_valid = (|head_oe) && (|head_load);

    // Request storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.req_src, bus.req_dst};
        end
    end

    // Queue bookkeeping, move FSM and registered bus strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.OE        <= '0;
            bus.notLoad   <= '1;
            bus.move_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            bus.OE        <= '0;
            bus.notLoad   <= '1;
            bus.move_done <= 1'b0;

            case (state)
                IDLE, SETTLE: begin
                    if (pop) begin
                        state <= DRIVE;
                        if (head_valid) begin
                            bus.OE      <= head_oe;
                            bus.notLoad <= ~head_load;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    state         <= SETTLE;
                    bus.move_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Self-checking bench for reg_move_sequencer: table-driven move vectors with a
// strobe scoreboard, plus hand-written queue-fill, reset and no-op sequences.
module tb_reg_move_sequencer;

    typedef struct {
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] exp_oe;
        logic [7:0] exp_nl;
    } vec_t;

    typedef struct packed {
        logic [7:0] oe;
        logic [7:0] nl;
    } exp_t;

    logic clock;
    logic reset;

    reg_move_sequencer_if #(.NUM_REGS(8), .IDX_WIDTH(3)) bus();
    reg_move_sequencer_if #(.NUM_REGS(6), .IDX_WIDTH(3)) bus6();

    reg_move_sequencer #(.NUM_REGS(8), .IDX_WIDTH(3), .FIFO_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    reg_move_sequencer #(.NUM_REGS(6), .IDX_WIDTH(3), .FIFO_DEPTH(4)) dut6 (
        .clock (clock),
        .reset (reset),
        .bus   (bus6)
    );

    vec_t       vecs [11];
    exp_t       sb [$];
    int         done_cycles [$];
    int         tests;
    int         fails;
    int         cycle;
    int         stalls;
    exp_t       next_exp;
    logic [7:0] prev_oe;
    logic [7:0] prev_nl;

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop so a hung design still produces a verdict.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t model(input logic [2:0] s, input logic [2:0] d);
        exp_t e;
        e.oe = 8'd1 << s;
        e.nl = ~(8'd1 << d);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Per-cycle monitor at the falling edge: one-hot OE, and on move_done the
    // previous cycle's strobes are compared against the oldest expected move.
    task automatic sampleBus();
        exp_t e;
        if (bus.OE != '0) begin
            checkOutput("oe_onehot", $countones(bus.OE), 1);
        end
        if (bus.move_done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got move_done=1, expected no pending move (cycle %0d)", cycle);
            end else begin
                e = sb.pop_front();
                checkOutput("drive_oe", prev_oe, e.oe);
                checkOutput("drive_nl", prev_nl, e.nl);
                checkOutput("settle_oe", bus.OE, 8'h00);
                checkOutput("settle_nl", bus.notLoad, 8'hFF);
                done_cycles.push_back(cycle);
            end
        end
        prev_oe = bus.OE;
        prev_nl = bus.notLoad;
    endtask

    // One clock: note whether the request is taken at this edge, then sample.
    task automatic step();
        logic acc;
        acc = bus.req_valid && bus.req_ready && !reset;
        @(posedge clock);
        if (acc) begin
            sb.push_back(next_exp);
        end
        cycle++;
        @(negedge clock);
        sampleBus();
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [2:0] s, input logic [2:0] d,
                                 input logic [7:0] eoe, input logic [7:0] enl);
        logic got;
        got = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_src   = s;
        bus.req_dst   = d;
        next_exp      = '{oe: eoe, nl: enl};
        for (int i = 0; i < 50 && !got; i++) begin
            got = bus.req_ready;
            if (!got) begin
                stalls++;
            end
            step();
        end
        bus.req_valid = 1'b0;
        if (!got) begin
            checkOutput("accept_timeout", 32'(got), 32'd1);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (sb.size() != 0 || bus.busy); i++) begin
            step();
        end
        checkOutput("drain_sb_empty", sb.size(), 0);
        checkOutput("drain_idle", bus.busy, 0);
    endtask

    // Single move on the six-register instance, checked cycle by cycle.
    task automatic run6(input logic [2:0] s, input logic [2:0] d,
                        input logic [5:0] eoe, input logic [5:0] enl);
        bus6.req_valid = 1'b1;
        bus6.req_src   = s;
        bus6.req_dst   = d;
        @(posedge clock);
        @(negedge clock);
        bus6.req_valid = 1'b0;
        checkOutput("r6_accept_busy", bus6.busy, 1);
        checkOutput("r6_accept_oe", bus6.OE, 6'h00);
        @(posedge clock);
        @(negedge clock);
        checkOutput("r6_drive_oe", bus6.OE, eoe);
        checkOutput("r6_drive_nl", bus6.notLoad, enl);
        checkOutput("r6_drive_done", bus6.move_done, 0);
        @(posedge clock);
        @(negedge clock);
        checkOutput("r6_settle_done", bus6.move_done, 1);
        checkOutput("r6_settle_oe", bus6.OE, 6'h00);
        checkOutput("r6_settle_nl", bus6.notLoad, 6'h3F);
        @(posedge clock);
        @(negedge clock);
        checkOutput("r6_after_done", bus6.move_done, 0);
        checkOutput("r6_after_busy", bus6.busy, 0);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        cycle  = 0;
        stalls = 0;
        prev_oe = 8'h00;
        prev_nl = 8'hFF;
        next_exp = '{oe: 8'h00, nl: 8'hFF};

        vecs[0]  = '{3'd0, 3'd1, 8'h01, 8'hFD};
        vecs[1]  = '{3'd1, 3'd2, 8'h02, 8'hFB};
        vecs[2]  = '{3'd2, 3'd3, 8'h04, 8'hF7};
        vecs[3]  = '{3'd3, 3'd4, 8'h08, 8'hEF};
        vecs[4]  = '{3'd4, 3'd5, 8'h10, 8'hDF};
        vecs[5]  = '{3'd5, 3'd6, 8'h20, 8'hBF};
        vecs[6]  = '{3'd6, 3'd7, 8'h40, 8'h7F};
        vecs[7]  = '{3'd7, 3'd0, 8'h80, 8'hFE};
        vecs[8]  = '{3'd0, 3'd1, 8'h01, 8'hFD};
        vecs[9]  = '{3'd1, 3'd2, 8'h02, 8'hFB};
        vecs[10] = '{3'd3, 3'd3, 8'h08, 8'hF7};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_src    = 3'd0;
        bus.req_dst    = 3'd0;
        bus6.req_valid = 1'b0;
        bus6.req_src   = 3'd0;
        bus6.req_dst   = 3'd0;

        // Reset state.
        repeat (2) @(negedge clock);
        checkOutput("rst_oe", bus.OE, 8'h00);
        checkOutput("rst_nl", bus.notLoad, 8'hFF);
        checkOutput("rst_done", bus.move_done, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_ready", bus.req_ready, 1);
        reset = 1'b0;

        // Single move 2 -> 5 with exact latency.
        applyStimulus(3'd2, 3'd5, 8'h04, 8'hDF);
        checkOutput("single_e0_busy", bus.busy, 1);
        checkOutput("single_e0_oe", bus.OE, 8'h00);
        step();
        checkOutput("single_e1_oe", bus.OE, 8'h04);
        checkOutput("single_e1_nl", bus.notLoad, 8'hDF);
        checkOutput("single_e1_done", bus.move_done, 0);
        step();
        checkOutput("single_e2_done", bus.move_done, 1);
        checkOutput("single_e2_oe", bus.OE, 8'h00);
        step();
        checkOutput("single_e3_done", bus.move_done, 0);
        checkOutput("single_e3_busy", bus.busy, 0);

        // Table: wrap-around sequence plus a self move.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].src, vecs[i].dst, vecs[i].exp_oe, vecs[i].exp_nl);
        end
        drain(100);

        // Queue fill: eight back-to-back requests, exactly one stall while full.
        stalls = 0;
        done_cycles.delete();
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e = model(3'(i), 3'(7 - i));
            applyStimulus(3'(i), 3'(7 - i), e.oe, e.nl);
        end
        checkOutput("fill_stalls", stalls, 1);
        drain(100);
        checkOutput("fill_done_count", done_cycles.size(), 8);
        for (int i = 1; i < done_cycles.size(); i++) begin
            checkOutput("fill_spacing", done_cycles[i] - done_cycles[i-1], 2);
        end

        // Reset in the middle of a DRIVE cycle with moves still queued.
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e = model(3'(i + 1), 3'(i));
            applyStimulus(3'(i + 1), 3'(i), e.oe, e.nl);
        end
        for (int i = 0; i < 10 && bus.OE == '0; i++) begin
            step();
        end
        checkOutput("pre_reset_in_drive", (bus.OE != '0), 1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_oe", bus.OE, 8'h00);
        checkOutput("midrst_nl", bus.notLoad, 8'hFF);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_ready", bus.req_ready, 1);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("midrst_no_done", bus.move_done, 0);
        end
        reset = 1'b0;
        step();
        checkOutput("post_rst_idle", bus.busy, 0);
        applyStimulus(3'd6, 3'd0, 8'h40, 8'hFE);
        drain(20);

        // Six-register instance: out-of-range source is a timed no-op.
        run6(3'd7, 3'd1, 6'h00, 6'h3F);
        run6(3'd4, 3'd5, 6'h10, 6'h1F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
